// File: rtl/bin_thresh_ctrl.sv
// Adaptive binarization threshold: per-frame mean of the gray stream plus a signed offset.
// The new threshold is only applied between frames, so the binarizer never sees a mid-frame change.
module bin_thresh_ctrl #(
   parameter int         CNT_W     = 19,
   parameter logic [7:0] DEF_VALUE = 8'd128
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] din,
   input  logic       din_vld,
   input  logic       din_sop,
   input  logic       din_eop,
   input  logic       auto_en,
   input  logic [7:0] manual_value,
   input  logic [7:0] offset,
   output logic [7:0] value,
   output logic       value_upd,
   output logic       busy,
   output logic       frame_err,
   output logic       overrun
);

   localparam int SUM_W = 8 + CNT_W;
   localparam int BIT_W = $clog2(SUM_W);

   typedef enum logic [1:0] {IDLE, DIV, CALC} state_t;

   state_t             state_q, state_d;
   logic [SUM_W-1:0]   sum_q, sum_d, sumSnap_q, sumSnap_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d, cntSnap_q, cntSnap_d;
   logic               inFrame_q, inFrame_d;
   logic               divReq_q, divReq_d;
   logic               autoSnap_q, autoSnap_d;
   logic [SUM_W-1:0]   quo_q, quo_d;
   logic [CNT_W-1:0]   rem_q, rem_d, den_q, den_d;
   logic [BIT_W-1:0]   bitCnt_q, bitCnt_d;
   logic [7:0]         pendVal_q, pendVal_d, value_q, value_d;
   logic               pending_q, pending_d;
   logic               valueUpd_q, valueUpd_d;
   logic               frameErr_q, frameErr_d;
   logic               overrun_q, overrun_d;

   logic [CNT_W:0]     remShift;
   logic               remGe;
   logic [9:0]         tSum;

   assign remShift = {rem_q, quo_q[SUM_W-1]};
   assign remGe    = (remShift >= {1'b0, den_q});
   // Quotient never exceeds 255, so a 10-bit signed sum covers -128..382 for saturation.
   assign tSum     = {2'b00, quo_q[7:0]} + {{2{offset[7]}}, offset};

   always_comb begin
      state_d    = state_q;
      sum_d      = sum_q;
      cnt_d      = cnt_q;
      sumSnap_d  = sumSnap_q;
      cntSnap_d  = cntSnap_q;
      inFrame_d  = inFrame_q;
      divReq_d   = 1'b0;
      autoSnap_d = autoSnap_q;
      quo_d      = quo_q;
      rem_d      = rem_q;
      den_d      = den_q;
      bitCnt_d   = bitCnt_q;
      pendVal_d  = pendVal_q;
      pending_d  = pending_q;
      value_d    = value_q;
      valueUpd_d = 1'b0;
      frameErr_d = 1'b0;
      overrun_d  = overrun_q;

      if (din_vld) begin
         if (din_sop) begin
            sum_d     = SUM_W'(din);
            cnt_d     = CNT_W'(1);
            inFrame_d = 1'b1;
            if (inFrame_q) frameErr_d = 1'b1;
         end else if (inFrame_q) begin
            sum_d = sum_q + SUM_W'(din);
            cnt_d = cnt_q + CNT_W'(1);
         end
         if (din_eop) begin
            if (din_sop || inFrame_q) begin
               inFrame_d  = 1'b0;
               autoSnap_d = auto_en;
               sumSnap_d  = sum_d;
               cntSnap_d  = cnt_d;
               divReq_d   = auto_en;
            end else begin
               frameErr_d = 1'b1;
            end
         end
      end

      // Apply first so that a same-cycle CALC or manual write leaves the newer value pending.
      if (pending_q && !inFrame_q && !(din_vld && din_sop)) begin
         value_d    = pendVal_q;
         valueUpd_d = 1'b1;
         pending_d  = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (divReq_q) begin
               state_d  = DIV;
               quo_d    = sumSnap_q;
               den_d    = cntSnap_q;
               rem_d    = '0;
               bitCnt_d = '0;
            end
         end
         DIV: begin
            quo_d    = {quo_q[SUM_W-2:0], remGe};
            rem_d    = remGe ? CNT_W'(remShift - {1'b0, den_q}) : remShift[CNT_W-1:0];
            bitCnt_d = bitCnt_q + BIT_W'(1);
            if (bitCnt_q == BIT_W'(SUM_W - 1)) state_d = CALC;
         end
         CALC: begin
            state_d = IDLE;
            if (autoSnap_q) begin
               pendVal_d = tSum[9] ? 8'd0 : (tSum[8] ? 8'd255 : tSum[7:0]);
               pending_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (divReq_q && state_q != IDLE) overrun_d = 1'b1;

      if (din_vld && din_eop && (din_sop || inFrame_q) && !auto_en) begin
         pendVal_d = manual_value;
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         sum_q      <= '0;
         cnt_q      <= '0;
         sumSnap_q  <= '0;
         cntSnap_q  <= '0;
         inFrame_q  <= 1'b0;
         divReq_q   <= 1'b0;
         autoSnap_q <= 1'b0;
         quo_q      <= '0;
         rem_q      <= '0;
         den_q      <= '0;
         bitCnt_q   <= '0;
         pendVal_q  <= DEF_VALUE;
         pending_q  <= 1'b0;
         value_q    <= DEF_VALUE;
         valueUpd_q <= 1'b0;
         frameErr_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         sum_q      <= sum_d;
         cnt_q      <= cnt_d;
         sumSnap_q  <= sumSnap_d;
         cntSnap_q  <= cntSnap_d;
         inFrame_q  <= inFrame_d;
         divReq_q   <= divReq_d;
         autoSnap_q <= autoSnap_d;
         quo_q      <= quo_d;
         rem_q      <= rem_d;
         den_q      <= den_d;
         bitCnt_q   <= bitCnt_d;
         pendVal_q  <= pendVal_d;
         pending_q  <= pending_d;
         value_q    <= value_d;
         valueUpd_q <= valueUpd_d;
         frameErr_q <= frameErr_d;
         overrun_q  <= overrun_d;
      end
   end

   assign value     = value_q;
   assign value_upd = valueUpd_q;
   assign busy      = (state_q != IDLE);
   assign frame_err = frameErr_q;
   assign overrun   = overrun_q;

endmodule
